lcd_value_scheduler: RTL and testbench
======================================

Name: lcd_value_scheduler

Overview:
- Parametrised successor to the fixed two-value character selector feeding the LCD glyph renderer.
- Latches NUM_CH signed fixed-point readings, for example temperature and humidity ×100 from the calculate stage.
- Converts each reading to decimal sequentially, with sign, leading-zero blanking, a decimal point and saturation.
- Streams glyph codes plus screen coordinates to the renderer through a valid/ack handshake, redrawing only the channels whose value changed.

Parameters:
- NUM_CH, 2: number of displayed channels, one text row each.
- VAL_W, 16: width of each signed two's-complement reading.
- INT_DIGITS, 3: integer digits shown.
- FRAC_DIGITS, 2: fractional digits shown; a reading is in units of 10^-FRAC_DIGITS.
- X0, 16: x pixel of the first character.
- Y0, 40: y pixel of row 0.
- CHAR_W, 16: horizontal pitch per character.
- ROW_H, 32: vertical pitch per channel row.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- val_valid  in  1  one-cycle strobe; val_data is valid.
- val_data  in  NUM_CH*VAL_W  channel c occupies bits [c*VAL_W +: VAL_W].
- char_valid  out  1  glyph request pending.
- char_code  out  4  glyph index.
- char_x  out  16  glyph window x0.
- char_y  out  16  glyph window y0.
- char_ack  in  1  renderer finished the current glyph (single-cycle pulse).
- frame_done  out  1  one-cycle pulse at the end of each processed frame.
- busy  out  1  high from snapshot acceptance until frame_done.

Behaviour:
- Reset (asynchronous): char_valid=0, char_code=0, char_x=0, char_y=0, frame_done=0, busy=0. Clears the pending flag and sets force_all=1. Reset mid-emission abandons the frame; no further char_valid until a new val_valid.
- Glyph codes: 0-9 are digits, 10 is '.', 11 is '-', 12 is blank. The width-4 char_code field is fixed.
- Channel field: CPC = 2 + INT_DIGITS + FRAC_DIGITS characters, in this order: sign, integer digits MSD first, '.', fractional digits.
  - Character k of channel c is at char_x = X0 + k*CHAR_W and char_y = Y0 + c*ROW_H.
- Magnitude: absolute value computed in VAL_W+1 bits, so the most negative value is exact.
  - If the magnitude exceeds 10^(INT_DIGITS+FRAC_DIGITS) - 1, every digit shows 9; the sign is kept.
- Sign character: '-' if the reading is negative and its magnitude is nonzero, else blank.
- Leading-zero blanking: integer digits before the first nonzero digit show blank. The last integer digit and all fractional digits always show the digit.
- States:
  - IDLE → SNAP: on val_valid. Copy val_data to the working snapshot, set busy, set c=0.
  - SNAP → CHECK.
  - CHECK → CONV: if force_all=1 or snap[c] differs from last_drawn[c].
  - CHECK → NEXT: otherwise, skipping the channel.
  - CONV: sequential shift-add-3 binary-to-BCD over VAL_W+1 magnitude bits, then saturation. → EMIT.
  - EMIT: drive char_valid=1 with code, x and y for character k, from k=0. → WAIT.
  - WAIT: outputs held stable while waiting for char_ack.
    - On char_ack, drop char_valid for at least one cycle.
    - If k < CPC-1, increment k and go to EMIT.
    - Otherwise set last_drawn[c] = snap[c] and go to NEXT.
  - NEXT: if c < NUM_CH-1, increment c and go to CHECK. Otherwise pulse frame_done, clear force_all and busy, and go to IDLE.
- From IDLE, if pending=1, go to SNAP using the shadow register.
- Latency: first char_valid of a changed channel comes no later than VAL_W+5 cycles after entering CHECK for that channel.
- If no channel changed, frame_done pulses within NUM_CH+3 cycles of val_valid, and char_valid never rises.
- val_valid while busy: val_data is copied to the shadow register and pending is set. A later strobe overwrites the shadow (latest wins), and there is at most one queued frame.
- val_valid in the same cycle as frame_done also sets pending.
- char_ack while char_valid=0 is ignored.
- A char_ack held high for several cycles counts once per EMIT→WAIT entry only.

Decomposition:
- Shared package lcd_pkg:
  - glyph code constants GLYPH_DOT=10, GLYPH_MINUS=11, GLYPH_BLANK=12;
  - the 4-bit glyph code type;
  - the 16-bit coordinate type.
- Sub-module bin2bcd_seq (parametrised on bit width and number of digits):
  - start/done handshake;
  - shift-add-3, one bit per cycle;
  - outputs a BCD digit vector.
- The scheduler FSM, snapshot/shadow/last_drawn storage and the character formatter stay in lcd_value_scheduler.

Test Plan:
- After reset, val_valid with ch0=2345 and ch1=-512 → 14 glyphs in order, each acked after 3 cycles.
  - ch0 codes are 12,12,2,3,10,4,5 at x 16,32,...,112 and y=40.
  - ch1 codes are 11,12,12,5,10,1,2 at y=72.
  - Then a single frame_done pulse.
- Resend the identical values → zero char_valid, frame_done within 5 cycles. Then change only ch1 to 0 → only the 7 ch1 glyphs 12,12,12,0,10,0,0.
- Value ch0=-32768 → glyphs 11,3,2,7,10,6,8. Rebuild with INT_DIGITS=2 and value 32767 → glyphs 12,9,9,10,9,9, saturated.
- Backpressure: ack is withheld for 40 cycles → char_code, char_x and char_y are stable throughout.
  - A spurious ack while idle causes no state change.
  - A 5-cycle-long ack advances exactly one glyph.
- Two val_valid strobes during emission, the second carrying ch0=100 → exactly one extra frame after frame_done, drawing 12,12,12,1,10,0,0 for ch0.
- Assert rst in the middle of ch0's 4th glyph → all outputs 0 asynchronously. The next val_valid redraws both channels (force_all), even with unchanged values.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD value path.
// Glyph codes 0-9 are decimal digits; the remaining codes below are punctuation.
// glyph_req_t bundles one renderer request (code plus window origin).
package lcd_pkg;

  localparam int unsigned GLYPH_W = 4;
  localparam int unsigned COORD_W = 16;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam glyph_t GLYPH_DOT   = 4'd10;
  localparam glyph_t GLYPH_MINUS = 4'd11;
  localparam glyph_t GLYPH_BLANK = 4'd12;

  typedef struct packed {
    glyph_t code;
    coord_t x;
    coord_t y;
  } glyph_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_CHECK,
    S_CONV,
    S_EMIT,
    S_WAIT,
    S_NEXT
  } sched_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per cycle).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load bin and begin conversion (ignored while running)
//   bin           unsigned binary input
//   done          one-cycle pulse when bcd/overflow are final
//   bcd           DIGITS packed BCD digits, digit i at [4*i +: 4]; held until next start
//   overflow      value needed more than DIGITS digits (bcd then holds low digits only)
module bin2bcd_seq #(
  parameter int unsigned BITS   = 17,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITS-1:0]       bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);

  logic              run;
  logic [CNT_W-1:0]  cnt;
  logic [BITS-1:0]   sh;
  logic [4*DIGITS-1:0] adj;

  // Add 3 to every digit >= 5 before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Any bit shifted out of the top digit means the value does not fit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        run      <= 1'b1;
        cnt      <= CNT_W'(BITS);
        sh       <= bin;
        bcd      <= '0;
        overflow <= 1'b0;
      end else if (run) begin
        bcd      <= {adj[4*DIGITS-2:0], sh[BITS-1]};
        overflow <= overflow | adj[4*DIGITS-1];
        sh       <= sh << 1;
        cnt      <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_value_scheduler.sv
// Latches NUM_CH signed fixed-point readings, converts each changed channel to
// a decimal text field (sign, blanked integer digits, '.', fraction) and streams
// glyph requests to the renderer over a valid/ack handshake.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   val_valid         one-cycle strobe qualifying val_data
//   val_data          channel c at [c*VAL_W +: VAL_W], two's complement
//   char_valid        glyph request pending
//   char_code         glyph index (0-9 digit, 10 '.', 11 '-', 12 blank)
//   char_x, char_y    glyph window origin
//   char_ack          renderer finished the current glyph (rising edge counts)
//   frame_done        one-cycle pulse at end of each processed frame
//   busy              high from snapshot acceptance until frame_done
module lcd_value_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned VAL_W       = 16,
  parameter int unsigned INT_DIGITS  = 3,
  parameter int unsigned FRAC_DIGITS = 2,
  parameter int unsigned X0          = 16,
  parameter int unsigned Y0          = 40,
  parameter int unsigned CHAR_W      = 16,
  parameter int unsigned ROW_H       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     val_valid,
  input  logic [NUM_CH*VAL_W-1:0]  val_data,
  output logic                     char_valid,
  output logic [GLYPH_W-1:0]       char_code,
  output logic [COORD_W-1:0]       char_x,
  output logic [COORD_W-1:0]       char_y,
  input  logic                     char_ack,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int unsigned N_DIG = INT_DIGITS + FRAC_DIGITS;
  localparam int unsigned CPC   = 2 + N_DIG;
  localparam int unsigned MAG_W = VAL_W + 1;
  localparam int unsigned C_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned K_W   = $clog2(CPC);

  sched_state_t state, state_d;

  logic [NUM_CH*VAL_W-1:0] snap, shadow, last_drawn;
  logic                    pending, force_all;
  logic [C_W-1:0]          c;
  logic [K_W-1:0]          k;
  logic                    ack_prev, ack_hit;

  logic [VAL_W-1:0]        cur;
  logic [MAG_W-1:0]        cur_ext, cur_mag;
  logic                    neg_nz, changed;

  logic                    conv_start, conv_done, conv_ovf;
  logic [4*N_DIG-1:0]      conv_bcd, disp;
  logic [N_DIG-1:0]        upper_zero;
  glyph_t                  field [CPC];

  glyph_req_t              req_q, req_d;
  logic                    char_valid_d, frame_done_d, busy_d;

  // Current channel value and its magnitude in VAL_W+1 bits (most negative is exact).
  assign cur     = snap[c*VAL_W +: VAL_W];
  assign cur_ext = {cur[VAL_W-1], cur};
  assign cur_mag = cur[VAL_W-1] ? (~cur_ext + MAG_W'(1)) : cur_ext;
  assign neg_nz  = cur[VAL_W-1] && (cur_mag != '0);
  assign changed = force_all || (cur != last_drawn[c*VAL_W +: VAL_W]);

  bin2bcd_seq #(
    .BITS   (MAG_W),
    .DIGITS (N_DIG)
  ) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .bin      (cur_mag),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Saturate to all nines when the magnitude does not fit the field.
  assign disp = conv_ovf ? {N_DIG{4'd9}} : conv_bcd;

  // upper_zero[j]: digits N_DIG-1 down to j are all zero.
  for (genvar g = 0; g < int'(N_DIG); g++) begin : g_lz
    assign upper_zero[g] = (disp[4*N_DIG-1:4*g] == '0);
  end

  // Glyph code for every character position of the field.
  for (genvar g = 0; g < int'(CPC); g++) begin : g_field
    if (g == 0) begin : g_sign
      assign field[g] = neg_nz ? GLYPH_MINUS : GLYPH_BLANK;
    end else if (g < int'(INT_DIGITS)) begin : g_int_lead
      assign field[g] = upper_zero[N_DIG-g] ? GLYPH_BLANK
                                            : glyph_t'(disp[4*(N_DIG-g) +: 4]);
    end else if (g == int'(INT_DIGITS)) begin : g_int_last
      assign field[g] = glyph_t'(disp[4*(N_DIG-g) +: 4]);
    end else if (g == int'(INT_DIGITS) + 1) begin : g_dot
      assign field[g] = GLYPH_DOT;
    end else begin : g_frac
      assign field[g] = glyph_t'(disp[4*(N_DIG+1-g) +: 4]);
    end
  end

  // Only a fresh rising edge of ack while a request is up advances the field.
  assign ack_hit = char_valid && char_ack && !ack_prev;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    char_valid_d = 1'b0;
    req_d        = req_q;
    frame_done_d = 1'b0;
    conv_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!frame_done && (val_valid || pending)) state_d = S_SNAP;
      end
      S_SNAP: state_d = S_CHECK;
      S_CHECK: begin
        if (changed) begin
          conv_start = 1'b1;
          state_d    = S_CONV;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_CONV: begin
        if (conv_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        char_valid_d = 1'b1;
        req_d.code   = field[k];
        req_d.x      = COORD_W'(X0) + COORD_W'(k) * COORD_W'(CHAR_W);
        req_d.y      = COORD_W'(Y0) + COORD_W'(c) * COORD_W'(ROW_H);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        char_valid_d = char_valid;
        if (ack_hit) begin
          char_valid_d = 1'b0;
          state_d      = (k == K_W'(CPC-1)) ? S_NEXT : S_EMIT;
        end
      end
      S_NEXT: begin
        if (c == C_W'(NUM_CH-1)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      char_valid <= 1'b0;
      req_q      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      char_valid <= char_valid_d;
      req_q      <= req_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

  assign char_code = req_q.code;
  assign char_x    = req_q.x;
  assign char_y    = req_q.y;

  // Snapshot, queued frame, redraw bookkeeping and field/channel indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      shadow     <= '0;
      last_drawn <= '0;
      pending    <= 1'b0;
      force_all  <= 1'b1;
      c          <= '0;
      k          <= '0;
      ack_prev   <= 1'b0;
    end else begin
      ack_prev <= char_ack;
      // A strobe that cannot start a frame now is queued; latest wins.
      if (val_valid && (state != S_IDLE || frame_done)) begin
        shadow  <= val_data;
        pending <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (!frame_done) begin
            if (val_valid) begin
              snap    <= val_data;
              pending <= 1'b0;
            end else if (pending) begin
              snap    <= shadow;
              pending <= 1'b0;
            end
          end
        end
        S_SNAP:  c <= '0;
        S_CHECK: k <= '0;
        S_WAIT: begin
          if (ack_hit) begin
            if (k == K_W'(CPC-1)) last_drawn[c*VAL_W +: VAL_W] <= cur;
            else                  k <= k + 1'b1;
          end
        end
        S_NEXT: begin
          if (c == C_W'(NUM_CH-1)) force_all <= 1'b0;
          else                     c <= c + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_value_scheduler.sv
// Directed self-checking bench for lcd_value_scheduler: a default instance and
// a second instance with two integer digits for the saturation case.
`timescale 1ns/1ps
module tb_lcd_value_scheduler;

  typedef int row_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        val_valid;
  logic [31:0] val_data;
  logic        char_valid;
  logic [3:0]  char_code;
  logic [15:0] char_x, char_y;
  logic        char_ack;
  logic        frame_done, busy;

  logic        b_val_valid;
  logic [31:0] b_val_data;
  logic        b_char_valid;
  logic [3:0]  b_char_code;
  logic [15:0] b_char_x, b_char_y;
  logic        b_char_ack;
  logic        b_frame_done, b_busy;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int cv_rises = 0;
  logic cv_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_value_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .val_valid  (val_valid),
    .val_data   (val_data),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_ack   (char_ack),
    .frame_done (frame_done),
    .busy       (busy)
  );

  lcd_value_scheduler #(.INT_DIGITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .val_valid  (b_val_valid),
    .val_data   (b_val_data),
    .char_valid (b_char_valid),
    .char_code  (b_char_code),
    .char_x     (b_char_x),
    .char_y     (b_char_y),
    .char_ack   (b_char_ack),
    .frame_done (b_frame_done),
    .busy       (b_busy)
  );

  always @(posedge clk) begin
    if (frame_done) fd_count++;
    if (char_valid && !cv_prev) cv_rises++;
    cv_prev = char_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // f: 0 valid, 1 code, 2 x, 3 y, 4 frame_done, 5 busy
  function automatic logic [31:0] obs(input bit s, input int f);
    case (f)
      0: return s ? 32'(b_char_valid) : 32'(char_valid);
      1: return s ? 32'(b_char_code)  : 32'(char_code);
      2: return s ? 32'(b_char_x)     : 32'(char_x);
      3: return s ? 32'(b_char_y)     : 32'(char_y);
      4: return s ? 32'(b_frame_done) : 32'(frame_done);
      default: return s ? 32'(b_busy) : 32'(busy);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] v0, input logic [15:0] v1);
    val_data  = {v1, v0};
    val_valid = 1'b1;
    tick(1);
    val_valid = 1'b0;
  endtask

  task automatic recv_glyph(input string tag, input bit s, input int code,
                            input int x, input int y, input int delay);
    int n = 0;
    while (obs(s, 0) !== 32'd1 && n < 80) begin
      tick(1);
      n++;
    end
    check({tag, ".valid"}, obs(s, 0), 1);
    check({tag, ".code"},  obs(s, 1), code);
    check({tag, ".x"},     obs(s, 2), x);
    check({tag, ".y"},     obs(s, 3), y);
    tick(delay);
    if (s) b_char_ack = 1'b1; else char_ack = 1'b1;
    tick(1);
    char_ack   = 1'b0;
    b_char_ack = 1'b0;
    check({tag, ".drop"}, obs(s, 0), 0);
  endtask

  task automatic recv_row(input string tag, input bit s, input row_t codes,
                          input int first, input int last, input int y, input int delay);
    for (int i = first; i <= last; i++)
      recv_glyph($sformatf("%s.k%0d", tag, i), s, codes[i], 16 + 16 * i, y, delay);
  endtask

  task automatic wait_frame(input string tag, input bit s);
    int n = 0;
    while (obs(s, 4) !== 32'd1 && n < 60) begin
      tick(1);
      n++;
    end
    check({tag, ".frame_done"}, obs(s, 4), 1);
    tick(1);
    check({tag, ".busy_after"}, obs(s, 5), 0);
  endtask

  initial begin
    row_t r;
    int   fd_base, cv_base, n;
    logic stable;

    rst = 1'b1; val_valid = 1'b0; val_data = '0; char_ack = 1'b0;
    b_val_valid = 1'b0; b_val_data = '0; b_char_ack = 1'b0;
    tick(3);
    check("rst.valid", 32'(char_valid), 0);
    check("rst.code",  32'(char_code), 0);
    check("rst.x",     32'(char_x), 0);
    check("rst.y",     32'(char_y), 0);
    check("rst.fd",    32'(frame_done), 0);
    check("rst.busy",  32'(busy), 0);
    rst = 1'b0;
    tick(2);

    // Spurious ack while idle
    char_ack = 1'b1; tick(1); char_ack = 1'b0; tick(3);
    check("spur.valid", 32'(char_valid), 0);
    check("spur.busy",  32'(busy), 0);

    // First frame: 23.45 and -5.12
    fd_base = fd_count;
    send(16'd2345, 16'hFE00);
    check("f1.busy", 32'(busy), 1);
    r = '{12, 12, 2, 3, 10, 4, 5, 0};
    recv_row("f1.r0", 1'b0, r, 0, 6, 40, 3);
    r = '{11, 12, 12, 5, 10, 1, 2, 0};
    recv_row("f1.r1", 1'b0, r, 0, 6, 72, 3);
    wait_frame("f1", 1'b0);
    tick(5);
    check("f1.fd_count", 32'(fd_count - fd_base), 1);

    // Identical values: no glyphs, quick frame_done
    cv_base = cv_rises;
    send(16'd2345, 16'hFE00);
    n = 1;
    tick(1);
    while (!frame_done && n < 5) begin
      tick(1);
      n++;
    end
    check("same.fd_in5", 32'(frame_done), 1);
    tick(3);
    check("same.no_valid", 32'(cv_rises - cv_base), 0);

    // Only ch1 changes to 0
    cv_base = cv_rises;
    send(16'd2345, 16'd0);
    r = '{12, 12, 12, 0, 10, 0, 0, 0};
    recv_row("f3.r1", 1'b0, r, 0, 6, 72, 2);
    wait_frame("f3", 1'b0);
    check("f3.glyph_count", 32'(cv_rises - cv_base), 7);

    // Most negative value, backpressure and a long ack
    send(16'h8000, 16'd0);
    n = 0;
    while (!char_valid && n < 80) begin
      tick(1);
      n++;
    end
    check("bp.code0", 32'(char_code), 11);
    stable = 1'b1;
    repeat (40) begin
      tick(1);
      if (char_valid !== 1'b1 || char_code !== 4'd11 || char_x !== 16'd16 || char_y !== 16'd40)
        stable = 1'b0;
    end
    check("bp.stable", 32'(stable), 1);
    char_ack = 1'b1; tick(5); char_ack = 1'b0;
    check("longack.valid", 32'(char_valid), 1);
    check("longack.code",  32'(char_code), 3);
    check("longack.x",     32'(char_x), 32);
    r = '{11, 3, 2, 7, 10, 6, 8, 0};
    recv_row("f4.r0", 1'b0, r, 1, 6, 40, 1);
    wait_frame("f4", 1'b0);

    // Two strobes during emission: one extra frame with the latest value
    fd_base = fd_count;
    send(16'd777, 16'd0);
    r = '{12, 12, 12, 7, 10, 7, 7, 0};
    recv_row("f5.r0", 1'b0, r, 0, 0, 40, 1);
    send(16'd500, 16'd0);
    send(16'd100, 16'd0);
    check("f5.busy", 32'(busy), 1);
    recv_row("f5.r0", 1'b0, r, 1, 6, 40, 1);
    wait_frame("f5", 1'b0);
    r = '{12, 12, 12, 1, 10, 0, 0, 0};
    recv_row("f6.r0", 1'b0, r, 0, 6, 40, 1);
    wait_frame("f6", 1'b0);
    tick(20);
    check("f6.fd_count", 32'(fd_count - fd_base), 2);
    check("f6.idle_busy", 32'(busy), 0);

    // Reset during the 4th glyph of ch0
    send(16'd4321, 16'd0);
    r = '{12, 12, 4, 3, 10, 2, 1, 0};
    recv_row("f7.r0", 1'b0, r, 0, 2, 40, 1);
    n = 0;
    while (!char_valid && n < 80) begin
      tick(1);
      n++;
    end
    check("f7.k3code", 32'(char_code), 3);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 32'(char_valid), 0);
    check("arst.code",  32'(char_code), 0);
    check("arst.x",     32'(char_x), 0);
    check("arst.y",     32'(char_y), 0);
    check("arst.busy",  32'(busy), 0);
    tick(1);
    rst = 1'b0;
    cv_base = cv_rises;
    tick(10);
    check("arst.quiet", 32'(cv_rises - cv_base), 0);

    // Redraw of both rows after reset
    send(16'd4321, 16'd0);
    recv_row("f8.r0", 1'b0, r, 0, 6, 40, 1);
    r = '{12, 12, 12, 0, 10, 0, 0, 0};
    recv_row("f8.r1", 1'b0, r, 0, 6, 72, 1);
    wait_frame("f8", 1'b0);

    // Two integer digits: 327.67 saturates to 99.99
    b_val_data  = {16'd0, 16'd32767};
    b_val_valid = 1'b1;
    tick(1);
    b_val_valid = 1'b0;
    r = '{12, 9, 9, 10, 9, 9, 0, 0};
    recv_row("sat.r0", 1'b1, r, 0, 5, 40, 1);
    r = '{12, 12, 0, 10, 0, 0, 0, 0};
    recv_row("sat.r1", 1'b1, r, 0, 5, 72, 1);
    wait_frame("sat", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
